jk_bank_ctrl: RTL
=================

// Module: jk_bank_ctrl
// PURPOSE
//   Sequencer for a bank of WIDTH jk_flip_flop instances. Accepts SET/CLEAR/TOGGLE/HOLD
//   commands over a valid/ready interface and turns each into a timed train of J/K pulses
//   on the bank. Sits between a command source and the flop bank; reads q back for checking.
// PARAMETERS
//   WIDTH  4  number of JK flops in the bank (bits of mask, j, k, q)
//   CNT_W  4  width of pulse-repeat count cmd_cnt
// PORTS
//   clk        in   1      single clock; all state updates on posedge
//   rstn       in   1      asynchronous, active-low reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      controller can accept a command (high only in IDLE)
//   cmd_op     in   2      0=HOLD 1=SET 2=CLEAR 3=TOGGLE
//   cmd_mask   in   WIDTH  flops affected by the command
//   cmd_cnt    in   CNT_W  number of J/K pulses to issue (0 = none)
//   j          out  WIDTH  to jk_flip_flop.j, registered
//   k          out  WIDTH  to jk_flip_flop.k, registered
//   q          in   WIDTH  from jk_flip_flop.q
//   busy       out  1      command in progress (state != IDLE)
//   done       out  1      one-cycle pulse at command completion
//   err        out  1      sticky readback mismatch (JK_CHECK_EN only; else tied 0)
//   err_clr    in   1      synchronous clear of err
// BEHAVIOUR
// - Reset (rstn=0, async): j=k=0, cmd_ready=1, busy=0, done=0, err=0, state=IDLE,
//   internal op/mask/remaining-count cleared. Reset mid-command aborts it; j/k drop at once.
// - States: IDLE -> DRIVE <-> SETTLE -> DONE -> IDLE.
// - IDLE: cmd_ready=1. Handshake = cmd_valid & cmd_ready at posedge (edge E0): latch op,
//   mask, cnt; snapshot q. cnt!=0 -> DRIVE; cnt==0 -> DONE (no J/K activity).
//   cmd_valid without ready is ignored; command fields must be held only until accepted.
// - DRIVE (1 cycle): j/k = HOLD 0/0, SET mask/0, CLEAR 0/mask, TOGGLE mask/mask.
//   Unmasked bits always j=k=0. Flops sample this at the next edge. -> SETTLE.
// - SETTLE (1 cycle): j=k=0, remaining count decremented; q now reflects the pulse.
//   remaining>0 -> DRIVE, else -> DONE.
// - DONE (1 cycle): done=1, j=k=0. -> IDLE (cmd_ready=1 next cycle).
// - Timing: cmd_cnt=N>0 -> N DRIVE/SETTLE pairs; done high in cycle 2N+1 after E0
//   (cycle 1 = first after E0); next command accepted no earlier than 2N+2 cycles after E0.
//   cmd_cnt=0 -> done in cycle 1.
// - j and k never both high on a bit outside TOGGLE; never high outside DRIVE.
// - busy = (state != IDLE). done and cmd_ready never high together.
// - Count is unsigned CNT_W bits; max 2^CNT_W-1 pulses; no wrap (decrement stops at 0).
// - err_clr and new mismatch in same cycle: mismatch wins (err stays 1).
// CONFIGURATION
//   JK_CHECK_EN defined: expected value computed at accept from q snapshot:
//     SET -> snapshot|mask; CLEAR -> snapshot&~mask; TOGGLE -> snapshot^(mask if N odd);
//     HOLD -> snapshot. Compared with q in the last SETTLE cycle; mismatch sets err
//     (sticky until err_clr or reset). cnt==0 skips the compare.
//   JK_CHECK_EN undefined: no snapshot/compare logic; err tied 0; err_clr ignored.
//   Cycle timing identical either way.
// TESTING (WIDTH=4, CNT_W=4, bank of 4 jk_flip_flop, 20-unit clock period)
// - Reset: rstn=0 then 1 -> j=k=0, cmd_ready=1, busy=0, done=0, err=0, q=4'b0000.
// - SET mask=4'b1010 cnt=1 -> j=1010,k=0000 for 1 cycle; done in cycle 3; q=1010.
// - TOGGLE mask=4'b1111 cnt=3 from q=1010 -> 3 pulses, done in cycle 7, q=0101, err=0.
// - CLEAR mask=4'b0100 cnt=0 -> no j/k activity, done in cycle 1, q unchanged=0101.
// - Reset asserted during 2nd DRIVE of TOGGLE cnt=5 -> j=k=0 immediately, busy=0,
//   no done pulse; next command accepted normally after release.
// - JK_CHECK_EN: force q bit0 stuck 0, SET mask=0001 cnt=1 -> err=1 at last SETTLE;
//   err_clr=1 one cycle -> err=0.

Source files
------------

// File: rtl/jk_bank_ctrl_if.sv
// Command and flop-bank bundle for jk_bank_ctrl. The command source and the flop bank
// are on the master side, and the controller is on the slave side.
interface jk_bank_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             err;
  logic             err_clr;

  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_cnt, q, err_clr,
    input  cmd_ready, j, k, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_cnt, q, err_clr,
    output cmd_ready, j, k, busy, done, err
  );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Turns SET/CLEAR/TOGGLE/HOLD commands into timed J/K pulse trains for a JK flop bank.
// Optional readback checker: define JK_CHECK_EN to enable the sticky err flag.
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rstn,
  jk_bank_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {OP_HOLD, OP_SET, OP_CLEAR, OP_TOGGLE} op_e;
  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, DONE} state_e;

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] mask_q;
  logic [CNT_W-1:0] rem_q;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic             done_q;

  function automatic logic [WIDTH-1:0] drive_j(op_e op, logic [WIDTH-1:0] mask);
    return (op == OP_SET || op == OP_TOGGLE) ? mask : '0;
  endfunction

  function automatic logic [WIDTH-1:0] drive_k(op_e op, logic [WIDTH-1:0] mask);
    return (op == OP_CLEAR || op == OP_TOGGLE) ? mask : '0;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of the others; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      mask_q  <= '0;
      rem_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q   <= op_e'(bus.cmd_op);
            mask_q <= bus.cmd_mask;
            rem_q  <= bus.cmd_cnt;
            if (bus.cmd_cnt != '0) begin
              state_q <= DRIVE;
              j_q     <= drive_j(op_e'(bus.cmd_op), bus.cmd_mask);
              k_q     <= drive_k(op_e'(bus.cmd_op), bus.cmd_mask);
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DRIVE: begin
          j_q     <= '0;
          k_q     <= '0;
          rem_q   <= (rem_q != '0) ? rem_q - 1'b1 : '0;
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (rem_q != '0) begin
            state_q <= DRIVE;
            j_q     <= drive_j(op_q, mask_q);
            k_q     <= drive_k(op_q, mask_q);
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.cmd_ready = (state_q == IDLE);

`ifdef JK_CHECK_EN
  logic [WIDTH-1:0] exp_q;
  logic             err_q;

  function automatic logic [WIDTH-1:0] expect_q(op_e op, logic [WIDTH-1:0] mask,
                                                logic odd, logic [WIDTH-1:0] snap);
    case (op)
      OP_SET:    return snap | mask;
      OP_CLEAR:  return snap & ~mask;
      OP_TOGGLE: return odd ? (snap ^ mask) : snap;
      default:   return snap;
    endcase
  endfunction

  // rem_q == 0 in SETTLE marks the final pulse; a mismatch there outranks err_clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.cmd_valid)
        exp_q <= expect_q(op_e'(bus.cmd_op), bus.cmd_mask, bus.cmd_cnt[0], bus.q);
      if (state_q == SETTLE && rem_q == '0 && bus.q != exp_q)
        err_q <= 1'b1;
      else if (bus.err_clr)
        err_q <= 1'b0;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{bus.err_clr, bus.q};
  assign bus.err       = 1'b0;
`endif

endmodule
